i2c_target_regs: RTL and testbench

- I2C target (responder) giving an external I2C master byte-wide register access into the FPGA: IMU readback, heart-rate cap writes.
- Counterpart to the IMU I2C master on the same bus type.
- Sits between board SCL/SDA pads (open-drain, tri-stated at top level) and a simple synchronous register-port interface.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_target_regs_line_sync.sv | 68 ++++++
 rtl/i2c_target_regs.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared FSM state encoding and bit-level constants for the I2C target.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK_WAIT = 4'd8,
        ST_IGNORE    = 4'd9
    } i2c_state_t;

    localparam logic       I2C_ACK  = 1'b0;
    localparam logic       I2C_NACK = 1'b1;
    localparam logic [3:0] I2C_BITS = 4'd8;

endpackage

`default_nettype wire

// File: rtl/i2c_target_regs_line_sync.sv
// ============================================================================
// Module : i2c_line_sync
// Brief  : 2-FF synchronizers for SCL/SDA, optional spike filter
//          (I2C_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] w_pad;
    logic [1:0] w_line;
    logic [1:0] r_line_d;

    assign w_pad = {scl_in, sda_in};

    // Index 1 is SCL, index 0 is SDA; both lines see identical latency so
    // START/STOP are judged on coherent samples.
    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [1:0] r_sync;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sync <= 2'b11;
            else        r_sync <= {r_sync[0], w_pad[i]};
        end

`ifdef I2C_GLITCH_FILTER_EN
        logic [1:0] r_hist;
        logic       w_agree;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_hist <= 2'b11;
            else        r_hist <= {r_hist[0], r_sync[1]};
        end

        // Follow the input only once three consecutive samples agree.
        assign w_agree   = (r_sync[1] == r_hist[0]) && (r_hist[0] == r_hist[1]);
        assign w_line[i] = w_agree ? r_sync[1] : r_line_d[i];
`else
        assign w_line[i] = r_sync[1];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_line_d <= 2'b11;
        else        r_line_d <= w_line;
    end

    assign sda       = w_line[0];
    assign scl_rise  =  w_line[1] & ~r_line_d[1];
    assign scl_fall  = ~w_line[1] &  r_line_d[1];
    assign start_det =  w_line[1] &  r_line_d[1] &  r_line_d[0] & ~w_line[0];
    assign stop_det  =  w_line[1] &  r_line_d[1] & ~r_line_d[0] &  w_line[0];

endmodule

`default_nettype wire

// File: rtl/i2c_target_regs.sv
// ============================================================================
// Module : i2c_target_regs
// Brief  : I2C target giving an external master byte access to a register
//          port. Optional spike filter via I2C_GLITCH_FILTER_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         AW       = 4
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          rd_strobe,
    output logic          busy
);

    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_line_sync u_line_sync (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (w_sda),
        .scl_rise  (w_rise),
        .scl_fall  (w_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    i2c_state_t    r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [6:0]    r_shift, w_shift_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_sda_oe, w_oe_nxt;
    logic          r_wr_en, w_wr_en_nxt;
    logic [AW-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]    r_wr_data, w_wr_data_nxt;
    logic          r_rd_strobe, w_rd_strobe_nxt;
    logic          r_busy, w_busy_nxt;
    logic          w_load;
    logic [7:0]    w_byte;

    assign w_byte = {r_shift, w_sda};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_shift     <= 7'd0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
            r_rd_strobe <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rw        <= w_rw_nxt;
            r_sda_oe    <= w_oe_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_rd_strobe <= w_rd_strobe_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_ptr_nxt       = r_ptr;
        w_rw_nxt        = r_rw;
        w_oe_nxt        = r_sda_oe;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_rd_strobe_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        w_load          = 1'b0;

        if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_rise) begin
                    w_shift_nxt = w_byte[6:0];
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == I2C_BITS - 4'd1) begin
                        w_cnt_nxt = 4'd0;
                        if (w_byte[7:1] == DEV_ADDR) begin
                            w_state_nxt = ST_ADDR_ACK;
                            w_rw_nxt    = w_byte[0];
                            w_busy_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
                // First fall starts the ACK bit, second fall ends it.
                ST_ADDR_ACK: if (w_fall) begin
                    if (!r_sda_oe) begin
                        w_oe_nxt = ~I2C_ACK;
                    end else if (r_rw) begin
                        w_load = 1'b1;
                    end else begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = ST_PTR;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_PTR: if (w_rise) begin
                    w_shift_nxt = w_byte[6:0];
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == I2C_BITS - 4'd1) begin
                        w_ptr_nxt   = w_byte[AW-1:0];
                        w_state_nxt = ST_PTR_ACK;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (w_fall) begin
                    if (!r_sda_oe) begin
                        w_oe_nxt = ~I2C_ACK;
                    end else begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = ST_WDATA;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_WDATA: if (w_rise) begin
                    w_shift_nxt = w_byte[6:0];
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == I2C_BITS - 4'd1) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_ptr;
                        w_wr_data_nxt = w_byte;
                        w_ptr_nxt     = r_ptr + c_ptr_one;
                        w_state_nxt   = ST_WDATA_ACK;
                        w_cnt_nxt     = 4'd0;
                    end
                end
                ST_RDATA: if (w_fall) begin
                    if (r_cnt == I2C_BITS - 4'd1) begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = ST_RACK_WAIT;
                    end else begin
                        w_oe_nxt    = ~r_shift[6];
                        w_shift_nxt = {r_shift[5:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end
                end
                // Count parked at I2C_BITS marks a received master ACK.
                ST_RACK_WAIT: begin
                    if (w_rise) begin
                        if (w_sda == I2C_NACK) begin
                            w_state_nxt = ST_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_cnt_nxt = I2C_BITS;
                        end
                    end else if (w_fall && r_cnt == I2C_BITS) begin
                        w_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Byte load: MSB goes straight onto the line on this same SCL fall.
        if (w_load) begin
            w_state_nxt     = ST_RDATA;
            w_rd_strobe_nxt = 1'b1;
            w_shift_nxt     = rd_data[6:0];
            w_oe_nxt        = ~rd_data[7];
            w_ptr_nxt       = r_ptr + c_ptr_one;
            w_cnt_nxt       = 4'd0;
        end
    end

    assign sda_oe    = r_sda_oe;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_addr   = r_ptr;
    assign rd_strobe = r_rd_strobe;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
// ============================================================================
// Module : tb_i2c_target_regs
// Brief  : Bit-banged I2C master with scoreboard checking of bus responses
//          and register-port writes for i2c_target_regs.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target_regs;

    localparam int Q = 6;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_en, rd_strobe, busy;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'd0;

    exp_t       exp_bus_q[$];
    logic [7:0] obs_bus_q[$];
    wr_t        exp_wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    logic oe_seen = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    always #10 clk = ~clk;

    always @(posedge clk) rd_data <= {4'h0, rd_addr} ^ 8'hC0;

    i2c_target_regs #(.DEV_ADDR(7'h42), .AW(4)) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_strobe (rd_strobe),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        exp_bus_q.push_back('{name, {7'd0, exp_ack}});
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(a);
        obs_bus_q.push_back({7'd0, a});
    endtask

    task automatic recv(input logic [7:0] exp_b, input logic ack, input string name);
        logic [7:0] d;
        logic bt;
        d = 8'd0;
        exp_bus_q.push_back('{name, exp_b});
        for (int i = 7; i >= 0; i--) begin
            get_bit(bt);
            d[i] = bt;
        end
        put_bit(ack);
        obs_bus_q.push_back(d);
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        exp_wr_q.push_back('{a, d});
    endtask

    // Monitor: pairs bus observations with expectations and checks write strobes.
    initial begin
        exp_t e;
        wr_t w;
        logic [7:0] o;
        forever begin
            @(negedge clk);
            if (sda_oe) oe_seen = 1'b1;
            if (rd_strobe) strobe_cnt++;
            if (obs_bus_q.size() > 0) begin
                o = obs_bus_q.pop_front();
                if (exp_bus_q.size() == 0) begin
                    chk("bus_unexpected", {24'd0, o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_bus_q.pop_front();
                    chk(e.name, {24'd0, o}, {24'd0, e.val});
                end
            end
            if (wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    chk("wr_unexpected", {20'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", {28'd0, wr_addr}, {28'd0, w.a});
                    chk("wr_data", {24'd0, wr_data}, {24'd0, w.d});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic bt;

        tick(5);
        chk("rst_sda_oe",    {31'd0, sda_oe},    0);
        chk("rst_wr_en",     {31'd0, wr_en},     0);
        chk("rst_busy",      {31'd0, busy},      0);
        chk("rst_rd_strobe", {31'd0, rd_strobe}, 0);
        chk("rst_rd_addr",   {28'd0, rd_addr},   0);
        chk("rst_wr_addr",   {28'd0, wr_addr},   0);
        chk("rst_wr_data",   {24'd0, wr_data},   0);
        reset_n = 1'b1;
        tick(Q);

        // Burst write: pointer 3, data A5, 5A.
        bus_start();
        send(8'h84, 1'b0, "w1_addr_ack");
        send(8'h03, 1'b0, "w1_ptr_ack");
        chk("w1_busy", {31'd0, busy}, 1);
        exp_wr(4'h3, 8'hA5);
        send(8'hA5, 1'b0, "w1_d0_ack");
        exp_wr(4'h4, 8'h5A);
        send(8'h5A, 1'b0, "w1_d1_ack");
        bus_stop();
        chk("w1_busy_after_stop", {31'd0, busy}, 0);

        // Pointer E, repeated START, read with wrap; NACK ends the transfer.
        bus_start();
        send(8'h84, 1'b0, "r_waddr_ack");
        send(8'h0E, 1'b0, "r_ptr_ack");
        bus_start();
        send(8'h85, 1'b0, "r_raddr_ack");
        recv(8'hCE, 1'b0, "r_byte0");
        recv(8'hCF, 1'b0, "r_byte1");
        recv(8'hC0, 1'b1, "r_byte2_wrap");
        chk("r_busy_after_nack", {31'd0, busy}, 0);
        bus_stop();

        // Foreign address: no ACK at all, target never drives.
        oe_seen = 1'b0;
        bus_start();
        send(8'h86, 1'b1, "x_addr_nack");
        send(8'hFF, 1'b1, "x_data_nack");
        bus_stop();
        tick(2);
        chk("x_oe_quiet", {31'd0, oe_seen}, 0);
        chk("x_busy", {31'd0, busy}, 0);

        // STOP mid-byte discards the partial data byte.
        bus_start();
        send(8'h84, 1'b0, "s_addr_ack");
        send(8'h07, 1'b0, "s_ptr_ack");
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        bus_stop();
        chk("s_busy_after_stop", {31'd0, busy}, 0);
        bus_start();
        send(8'h84, 1'b0, "s2_addr_ack");
        send(8'h08, 1'b0, "s2_ptr_ack");
        exp_wr(4'h8, 8'h3C);
        send(8'h3C, 1'b0, "s2_data_ack");
        bus_stop();

        // One-cycle SDA low spike while SCL high.
        bus_start();
        send(8'h84, 1'b0, "g_addr_ack");
        send(8'h05, 1'b0, "g_ptr_ack");
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(1);
        sda_m = 1'b1; tick(Q);
`ifdef I2C_GLITCH_FILTER_EN
        chk("g_spike_busy", {31'd0, busy}, 1);
`else
        chk("g_spike_busy", {31'd0, busy}, 0);
`endif
        scl_m = 1'b0; tick(Q);
        bus_stop();
        chk("g_busy_after_stop", {31'd0, busy}, 0);

        // Reset asserted while the target drives SDA low during a read.
        bus_start();
        send(8'h85, 1'b0, "z_raddr_ack");
        get_bit(bt);
        get_bit(bt);
        chk("z_pre_oe", {31'd0, sda_oe}, 1);
        reset_n = 1'b0;
        #1;
        chk("z_async_oe", {31'd0, sda_oe}, 0);
        chk("z_async_busy", {31'd0, busy}, 0);
        tick(3);
        scl_m = 1'b1;
        tick(3);
        chk("z_rst_rd_addr", {28'd0, rd_addr}, 0);
        reset_n = 1'b1;
        tick(Q);
        bus_start();
        send(8'h84, 1'b0, "z_addr_ack");
        send(8'h00, 1'b0, "z_ptr_ack");
        exp_wr(4'h0, 8'h11);
        send(8'h11, 1'b0, "z_data_ack");
        bus_stop();

        tick(20);
        chk("bus_queue_drain", exp_bus_q.size(), 0);
        chk("wr_queue_drain", exp_wr_q.size(), 0);
        chk("rd_strobe_count", strobe_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
